// File: rtl/nib_pkg.sv
// Shared definitions for the nibble serializer.
//   NIB_WIDTH  : default word width
//   NIB_LANE   : lane width in bits
//   NIB_NLANES : lanes per word
//   nib_state_t: serializer FSM state
package nib_pkg;
    localparam int NIB_WIDTH  = 16;
    localparam int NIB_LANE   = 4;
    localparam int NIB_NLANES = NIB_WIDTH / NIB_LANE;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } nib_state_t;
endpackage

// File: rtl/lane_extend.sv
// Extends one LANE-bit lane to WIDTH bits, by sign or by zero.
//   lane_in   : lane bits
//   is_signed : 1 = replicate lane msb into the upper bits, 0 = zero-fill
//   data_out  : extended value
module lane_extend
    import nib_pkg::*;
#(
    parameter int WIDTH = NIB_WIDTH,
    parameter int LANE  = NIB_LANE
) (
    input  logic [LANE-1:0]  lane_in,
    input  logic             is_signed,
    output logic [WIDTH-1:0] data_out
);
    logic fill;

    always_comb begin
        fill     = is_signed & lane_in[LANE-1];
        data_out = {{(WIDTH-LANE){fill}}, lane_in};
    end
endmodule

// File: rtl/nib_serializer.sv
// Splits a word into LANE-bit lanes and emits them one beat at a time,
// lane 0 (lsbs) first, each extended to WIDTH bits.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : word handshake; in_data, in_signed qualify it
//   flush                   : synchronous abort of the word in progress
//   out_valid/out_ready     : beat handshake
//   out_data/out_idx/out_last : extended lane, lane index, final-lane flag
//   busy                    : a word is held
//
// state  | meaning
// S_IDLE | no word held, ready for a new one
// S_EMIT | word held, lane idx_q presented on the output
module nib_serializer
    import nib_pkg::*;
#(
    parameter int WIDTH = NIB_WIDTH,
    parameter int LANE  = NIB_LANE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_signed,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [$clog2(WIDTH/LANE)-1:0]     out_idx,
    output logic                              out_last,
    output logic                              busy
);
    localparam int NLANES = WIDTH / LANE;
    localparam int IDXW   = $clog2(NLANES);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NLANES - 1);

    nib_state_t        state_q, state_d;
    logic [WIDTH-1:0]  word_q,  word_d;
    logic              sgn_q,   sgn_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic              valid_q, valid_d;

    logic              last;
    logic              beat;
    logic              accept;
    logic [LANE-1:0]   lane_bits;

    always_comb begin
        last     = valid_q && (idx_q == IDX_LAST);
        beat     = valid_q && out_ready;
        // Final beat of one word and acceptance of the next may share a cycle.
        in_ready = !flush && ((state_q == S_IDLE) || (beat && last));
        accept   = in_valid && in_ready;

        state_d  = state_q;
        word_d   = word_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        valid_d  = valid_q;

        if (flush) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
        end else if (accept) begin
            state_d = S_EMIT;
            word_d  = in_data;
            sgn_d   = in_signed;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (beat) begin
            if (last) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Lane select is driven only by held state, so in_data never reaches out_data.
    always_comb begin
        lane_bits = word_q[int'(idx_q)*LANE +: LANE];
    end

    lane_extend #(.WIDTH(WIDTH), .LANE(LANE)) u_lane_extend (
        .lane_in   (lane_bits),
        .is_signed (sgn_q),
        .data_out  (out_data)
    );

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last;
    assign busy      = valid_q;
endmodule
